// File: rtl/sm3_pkg.sv
// Shared SM3 constants, round-state type and the boolean/permutation helpers
// used by the iterative compression core.
package sm3_pkg;

    localparam logic [255:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [31:0]  T_LOW  = 32'h79cc4519;
    localparam logic [31:0]  T_HIGH = 32'h7a879d8a;

    localparam int W_BASE     = 0;
    localparam int WP_BASE    = 68;
    localparam int NUM_WORDS  = 132;
    localparam int NUM_ROUNDS = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_e;

    // A sits in the top word so the packed struct lines up with the digest layout
    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } sm3_regs_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [5:0] rs;
        rs = 6'd32 - {1'b0, n};
        return (n == 5'd0) ? x : ((x << n) | (x >> rs));
    endfunction

    function automatic logic [31:0] P0(input logic [31:0] x);
        return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
    endfunction

    function automatic logic [31:0] FF(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic lo);
        return lo ? (x ^ y ^ z) : ((x & y) | (x & z) | (y & z));
    endfunction

    function automatic logic [31:0] GG(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic lo);
        return lo ? (x ^ y ^ z) : ((x & y) | (~x & z));
    endfunction

endpackage

// File: rtl/sm3_round.sv
// One combinational SM3 compression round: maps A..H plus Wj/W'j and the
// round index to the next A..H.
module sm3_round
    import sm3_pkg::*;
(
    input  sm3_regs_t   st_i,
    input  logic [31:0] w_i,
    input  logic [31:0] wp_i,
    input  logic [5:0]  j_i,
    output sm3_regs_t   st_o
);

    logic        lo;
    logic [31:0] tj, a12, ss1, ss2, tt1, tt2;

    assign lo  = (j_i < 6'd16);
    assign tj  = rotl32(lo ? T_LOW : T_HIGH, j_i[4:0]);
    assign a12 = rotl32(st_i.a, 5'd12);
    assign ss1 = rotl32(a12 + st_i.e + tj, 5'd7);
    assign ss2 = ss1 ^ a12;
    assign tt1 = FF(st_i.a, st_i.b, st_i.c, lo) + st_i.d + ss2 + wp_i;
    assign tt2 = GG(st_i.e, st_i.f, st_i.g, lo) + st_i.h + ss1 + w_i;

    always_comb begin
        st_o.a = tt1;
        st_o.b = st_i.a;
        st_o.c = rotl32(st_i.b, 5'd9);
        st_o.d = st_i.c;
        st_o.e = P0(tt2);
        st_o.f = st_i.e;
        st_o.g = rotl32(st_i.f, 5'd19);
        st_o.h = st_i.g;
    end

endmodule

// File: rtl/sm3_compress.sv
// Iterative SM3 CF: buffers one expanded block, runs 64 rounds at one per
// clock, chains V across blocks and publishes the digest after the last block.
module sm3_compress
    import sm3_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_WORDS*32-1:0] i_extend_data,
    input  logic                    i_extend_valid,
    input  logic                    i_first_block,
    input  logic                    i_last_block,
    output logic                    o_ready,
    output logic [255:0]            o_hash,
    output logic                    o_hash_valid,
    output logic                    o_overrun
);

    state_e                    state_q, state_d;
    logic [5:0]                j_q, j_d;
    logic [NUM_WORDS*32-1:0]   buf_q, buf_d;
    sm3_regs_t                 st_q, st_d, st_rnd;
    logic [255:0]              v_q, v_d, hash_q, hash_d;
    logic                      last_q, last_d, hvld_q, hvld_d;
    logic [31:0]               w_j, wp_j;

    assign w_j  = buf_q[32*(W_BASE  + int'(j_q)) +: 32];
    assign wp_j = buf_q[32*(WP_BASE + int'(j_q)) +: 32];

    sm3_round u_round (
        .st_i (st_q),
        .w_i  (w_j),
        .wp_i (wp_j),
        .j_i  (j_q),
        .st_o (st_rnd)
    );

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        buf_d   = buf_q;
        st_d    = st_q;
        v_d     = v_q;
        hash_d  = hash_q;
        last_d  = last_q;
        hvld_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_extend_valid) begin
                    buf_d   = i_extend_data;
                    last_d  = i_last_block;
                    j_d     = 6'd0;
                    state_d = ST_ROUND;
                    if (i_first_block) begin
                        v_d  = SM3_IV;
                        st_d = sm3_regs_t'(SM3_IV);
                    end else begin
                        st_d = sm3_regs_t'(v_q);
                    end
                end
            end
            ST_ROUND: begin
                st_d = st_rnd;
                j_d  = j_q + 6'd1;
                if (j_q == 6'(NUM_ROUNDS - 1)) state_d = ST_FINAL;
            end
            ST_FINAL: begin
                v_d     = v_q ^ st_q;
                state_d = ST_IDLE;
                if (last_q) begin
                    hash_d = v_q ^ st_q;
                    hvld_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            st_q    <= '0;
            v_q     <= SM3_IV;
            hash_q  <= '0;
            last_q  <= 1'b0;
            hvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            st_q    <= st_d;
            v_q     <= v_d;
            hash_q  <= hash_d;
            last_q  <= last_d;
            hvld_q  <= hvld_d;
        end
    end

    // Data-only storage; only read while a block is in flight
    always_ff @(posedge i_clk) begin
        buf_q <= buf_d;
    end

    assign o_ready      = (state_q == ST_IDLE);
    assign o_overrun    = i_extend_valid & (state_q != ST_IDLE);
    assign o_hash       = hash_q;
    assign o_hash_valid = hvld_q;

endmodule

// File: tb/tb_sm3_compress.sv
// Self-checking bench for sm3_compress: table of messages against a
// block-level SM3 reference model plus hand-written corner sequences.
module tb_sm3_compress;

    localparam logic [255:0] IV  = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [255:0] ABC = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] ABCD = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] ABCD_B1 = {16{32'h61626364}};
    localparam logic [511:0] ABCD_B2 = {32'h80000000, {14{32'h0}}, 32'h00000200};

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [4223:0]  i_extend_data = '0;
    logic           i_extend_valid = 1'b0;
    logic           i_first_block = 1'b0;
    logic           i_last_block = 1'b0;
    logic           o_ready, o_hash_valid, o_overrun;
    logic [255:0]   o_hash;

    sm3_compress dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_extend_data  (i_extend_data),
        .i_extend_valid (i_extend_valid),
        .i_first_block  (i_first_block),
        .i_last_block   (i_last_block),
        .o_ready        (o_ready),
        .o_hash         (o_hash),
        .o_hash_valid   (o_hash_valid),
        .o_overrun      (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, hv_cnt = 0, ov_cnt = 0;

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(negedge i_clk) begin
        #2;
        if (o_hash_valid) hv_cnt++;
        if (o_overrun)    ov_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
    endfunction

    function automatic void expand_words(input logic [511:0] b, output logic [31:0] w [68]);
        logic [31:0] t;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 68; i++) begin
            t = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
            w[i] = (t ^ rl(t, 15) ^ rl(t, 23)) ^ rl(w[i-13], 7) ^ w[i-6];
        end
    endfunction

    function automatic logic [4223:0] expand(input logic [511:0] b);
        logic [31:0]   w [68];
        logic [4223:0] r;
        expand_words(b, w);
        r = '0;
        for (int g = 0; g < 68; g++) r[g*32 +: 32] = w[g];
        for (int g = 0; g < 64; g++) r[(68+g)*32 +: 32] = w[g] ^ w[g+4];
        return r;
    endfunction

    function automatic logic [255:0] cf(input logic [255:0] v, input logic [511:0] b);
        logic [31:0] w [68];
        logic [31:0] r [8];
        logic [31:0] ss1, ss2, tt1, tt2, ff, gg, t;
        expand_words(b, w);
        for (int k = 0; k < 8; k++) r[k] = v[255 - 32*k -: 32];
        for (int j = 0; j < 64; j++) begin
            t  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rl(rl(r[0], 12) + r[4] + rl(t, j), 7);
            ss2 = ss1 ^ rl(r[0], 12);
            ff = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
            gg = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
            tt1 = ff + r[3] + ss2 + (w[j] ^ w[j+4]);
            tt2 = gg + r[7] + ss1 + w[j];
            r[3] = r[2]; r[2] = rl(r[1], 9); r[1] = r[0]; r[0] = tt1;
            r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4];
            r[4] = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
        end
        return {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]} ^ v;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [511:0] b, input bit f, input bit l);
        @(negedge i_clk);
        i_extend_data  = expand(b);
        i_first_block  = f;
        i_last_block   = l;
        i_extend_valid = 1'b1;
        @(negedge i_clk);
        i_extend_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_digest(input string name, input logic [255:0] exp, input bit scramble);
        int lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge i_clk);
            if (scramble) begin
                for (int g = 0; g < 132; g++) i_extend_data[g*32 +: 32] = $urandom;
                i_first_block = 1'($urandom);
                i_last_block  = 1'($urandom);
            end
            #3;
            if (o_hash_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        if (lat < 0) chk({name, "_timeout"}, 0, 1);
        else begin
            chk({name, "_latency"}, 256'(lat), 256'd65);
            chk({name, "_hash"}, o_hash, exp);
        end
    endtask

    typedef struct {
        logic [511:0] blk;
        bit           first;
        bit           last;
        logic [255:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [255:0] v;
        logic [511:0] rb;
        int save;

        // table: known vectors, random single blocks, random 3-block chain
        tbl[0] = '{ABC_BLK, 1'b1, 1'b1, ABC};
        tbl[1] = '{ABCD_B1, 1'b1, 1'b0, '0};
        tbl[2] = '{ABCD_B2, 1'b0, 1'b1, ABCD};
        v = IV;
        for (int i = 3; i < 9; i++) begin
            for (int k = 0; k < 16; k++) rb[k*32 +: 32] = $urandom;
            tbl[i].blk   = rb;
            tbl[i].first = (i <= 6);
            tbl[i].last  = (i <= 5) || (i == 8);
            if (tbl[i].first) v = IV;
            v = cf(v, rb);
            tbl[i].exp = v;
        end

        // reset state
        repeat (2) @(negedge i_clk);
        chk("rst_ready", 256'(o_ready), 1);
        chk("rst_hash", o_hash, 0);
        chk("rst_hvld", 256'(o_hash_valid), 0);
        chk("rst_ovr", 256'(o_overrun), 0);
        i_rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            wait_ready();
            save = hv_cnt;
            send(tbl[i].blk, tbl[i].first, tbl[i].last);
            if (tbl[i].last) wait_digest($sformatf("tbl%0d", i), tbl[i].exp, 1'b0);
            else begin
                repeat (70) @(negedge i_clk);
                chk($sformatf("tbl%0d_nohv", i), 256'(hv_cnt), 256'(save));
            end
        end
        chk("tbl_no_overrun", 256'(ov_cnt), 0);

        // valid while busy: dropped, overrun pulses once
        wait_ready();
        save = ov_cnt;
        send(ABC_BLK, 1'b1, 1'b1);
        repeat (9) @(negedge i_clk);
        i_extend_data[31:0] = 32'hdeadbeef;
        i_first_block  = 1'b1;
        i_extend_valid = 1'b1;
        @(negedge i_clk);
        i_extend_valid = 1'b0;
        wait_digest("ovr", ABC, 1'b0);
        chk("ovr_count", 256'(ov_cnt), 256'(save + 1));

        // reset mid-block aborts; replay with first=0 relies on reset V
        wait_ready();
        send(ABC_BLK, 1'b1, 1'b1);
        repeat (31) @(negedge i_clk);
        save = hv_cnt;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (80) @(negedge i_clk);
        chk("rst_mid_nohv", 256'(hv_cnt), 256'(save));
        chk("rst_mid_ready", 256'(o_ready), 1);
        chk("rst_mid_hash", o_hash, 0);
        send(ABC_BLK, 1'b0, 1'b1);
        wait_digest("replay", ABC, 1'b0);

        // abandoned message, then new message reloads IV
        wait_ready();
        for (int k = 0; k < 16; k++) rb[k*32 +: 32] = $urandom;
        send(rb, 1'b1, 1'b0);
        wait_ready();
        send(ABC_BLK, 1'b1, 1'b1);
        wait_digest("abandon", ABC, 1'b0);

        // upstream bus churns during rounds
        wait_ready();
        send(ABC_BLK, 1'b1, 1'b1);
        wait_digest("scramble", ABC, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm3_compress.md
Name: sm3_compress

Overview:
- Iterative SM3 compression function CF, directly downstream of Data_Extend.
- Consumes one expanded block (W0..W67, W'0..W'63) per acceptance and runs 64 rounds, one round per clock.
- Chains the intermediate hash V across the blocks of one message.
- Emits the 256-bit digest after the block flagged last; the result goes to the top-level SM3 output/AXI wrapper.

Parameters:
- SM3_IV, 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e, initial V loaded at the first block of each message.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_extend_data  input  4224  expanded words. Word g occupies bits [g*32+31:g*32]. g=0..67 is W_g; g=68..131 is W'_(g-68).
- i_extend_valid  input  1  single-cycle strobe; data is valid in that cycle.
- i_first_block  input  1  sampled with valid; 1 = start a new message from SM3_IV.
- i_last_block  input  1  sampled with valid; 1 = emit the digest after this block.
- o_ready  output  1  high when IDLE; a block can be accepted this cycle.
- o_hash  output  256  digest, A-word in [255:224]; held until the next digest.
- o_hash_valid  output  1  one-cycle pulse when o_hash updates.
- o_overrun  output  1  one-cycle pulse when valid arrives while not ready; that block is dropped.

Behaviour:
- Reset values:
  - all outputs 0 except o_ready=1.
  - V=SM3_IV; A..H=0; round counter=0; state IDLE.
  - Reset mid-operation aborts the block with no digest.
- States:
  - IDLE: o_ready=1. On valid at edge k:
    - latch all 132 words into an internal buffer;
    - if first, load V and A..H from SM3_IV, else load A..H from V;
    - latch the last flag; go to ROUND with j=0.
  - ROUND: edges k+1..k+64, one round per edge, j increments each round.
    - SS1=((A<<<12)+E+(Tj<<<(j mod 32)))<<<7; SS2=SS1^(A<<<12).
    - TT1=FFj(A,B,C)+D+SS2+W'j; TT2=GGj(E,F,G)+H+SS1+Wj.
    - D=C; C=B<<<9; B=A; A=TT1; H=G; G=F<<<19; F=E; E=P0(TT2).
    - Tj = 79cc4519 for j<16, 7a879d8a otherwise.
    - FF: XOR for j<16, majority otherwise.
    - GG: XOR for j<16, (E&F)|(~E&G) otherwise.
    - P0(X) = X^(X<<<9)^(X<<<17).
    - All adds are modulo 2^32; rotations are within 32 bits.
    - After j=63 go to FINAL.
  - FINAL: edge k+65. V <= {A..H}^V. If last: o_hash <= the new V and o_hash_valid=1 for that one cycle. Return to IDLE, so o_ready=1 after edge k+65.
- Latency:
  - digest visible 65 edges after acceptance;
  - minimum block-to-block spacing is 66 cycles.
- Word selection: Wj and W'j are muxed from the buffer by j. The upstream bus may change during ROUND without effect.
- Valid while ROUND/FINAL: block dropped, o_overrun pulses, state unaffected.
- first=1 while the previous message has not finished: the new message still restarts from SM3_IV, and V of the unfinished message is discarded.
- first=0 as the very first block after reset: uses V=SM3_IV (reset value).
- first and last both 1: single-block message.

Decomposition:
- Package sm3_pkg:
  - SM3_IV, T_LOW=32'h79cc4519, T_HIGH=32'h7a879d8a;
  - rotl32, P0, FF, GG functions;
  - word index constants (W base 0, W' base 68), state encoding.
- Sub-module sm3_round: one combinational round. Inputs A..H, Wj, W'j, j. Outputs next A..H. The top holds the FSM, buffer, counter and V.

Test Plan:
- "abc": one block 61626380_00000000×14_00000018 expanded, first=last=1 → o_hash=66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0, o_hash_valid exactly 65 edges after acceptance.
- Two-block "abcd"×16 (first=1/last=0, then first=0/last=1, fed back-to-back at o_ready) → debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732; no o_hash_valid after the first block.
- Valid pulse 10 cycles after acceptance → o_overrun one cycle, digest still equals the "abc" value.
- Assert i_rst at round 30 of "abc", then replay → no o_hash_valid from the aborted block, replay yields the correct digest.
- Abandon a message after its first block (last=0), then send "abc" with first=1 → "abc" digest, proving the IV reload.
- Upstream bus randomized during ROUND after acceptance → "abc" digest unchanged.
